// File: rtl/minibyte_pkg.sv
// Shared definitions for the minibyte register-RAM initiator: FSM states and
// the layout of a queued request word {we, addr, data}.
package minibyte_pkg;

  localparam int MB_ADDR_W = 2;
  localparam int MB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Request word packs data in the low bits, address above it, write flag on top.
  localparam int REQ_DATA_LSB = 0;

  function automatic int req_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int req_we_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/reg_ram_req_fifo.sv
// Small synchronous FIFO holding pending RAM requests; push and pop may
// happen on the same edge.
module reg_ram_req_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/reg_ram_master.sv
// Initiator for the 4-byte register RAM: queues requests, issues one RAM
// access per cycle in order, and returns read data over a valid/ready channel.
module reg_ram_master
  import minibyte_pkg::*;
#(
  parameter int ADDR_W     = MB_ADDR_W,
  parameter int DATA_W     = MB_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_we_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [DATA_W-1:0] req_data_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [DATA_W-1:0] rsp_data_out,
  output logic [ADDR_W-1:0] rsp_addr_out,
  output logic [ADDR_W-1:0] mem_address_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_we_out,
  output logic              mem_en_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              busy_out
);

  localparam int REQ_W    = req_width(ADDR_W, DATA_W);
  localparam int ADDR_LSB = req_addr_lsb(DATA_W);
  localparam int WE_BIT   = req_we_bit(ADDR_W, DATA_W);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [REQ_W-1:0]  op_q, op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [REQ_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              rsp_capture;

  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;

  assign op_we   = op_q[WE_BIT];
  assign op_addr = op_q[ADDR_LSB +: ADDR_W];
  assign op_data = op_q[REQ_DATA_LSB +: DATA_W];

  assign req_ready_out = !fifo_full;
  assign fifo_push     = req_valid_in && !fifo_full;

  reg_ram_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (fifo_push),
    .wdata_i ({req_we_in, req_addr_in, req_data_in}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State register and response registers are control-visible; op_q is only
  // consumed in ACCESS, which is always entered through a pop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    op_q <= op_d;
  end

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    rsp_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (op_we) begin
          fifo_pop = !fifo_empty;
          state_d  = fifo_empty ? ST_IDLE : ST_ACCESS;
        end else begin
          rsp_capture = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_in) begin
          fifo_pop = !fifo_empty;
          state_d  = fifo_empty ? ST_IDLE : ST_ACCESS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d       = fifo_pop ? fifo_rdata : op_q;
    rsp_data_d = rsp_capture ? mem_data_in : rsp_data_q;
    rsp_addr_d = rsp_capture ? op_addr : rsp_addr_q;
  end

  // RAM enables are gated by reset so an in-flight access is aborted.
  always_comb begin
    mem_en_out      = (state_q == ST_ACCESS) && !rst_in;
    mem_we_out      = (state_q == ST_ACCESS) && op_we && !rst_in;
    mem_address_out = (state_q == ST_ACCESS) ? op_addr : '0;
    mem_data_out    = ((state_q == ST_ACCESS) && op_we) ? op_data : '0;
    rsp_valid_out   = (state_q == ST_RESP);
    busy_out        = (state_q != ST_IDLE) || (fifo_count != '0);
  end

  assign rsp_data_out = rsp_data_q;
  assign rsp_addr_out = rsp_addr_q;

endmodule
